// File: rtl/idex_pkg.sv
// Shared widths, field indices and occupancy encoding for the ID->EX pipeline stage.
package idex_pkg;

  localparam int unsigned DW_DEF  = 16;
  localparam int unsigned CW_DEF  = 16;
  localparam int unsigned RW_DEF  = 4;
  localparam int unsigned NDF_DEF = 3;
  localparam int unsigned NRF_DEF = 4;

  localparam int unsigned RS_IDX  = 0;
  localparam int unsigned RT1_IDX = 1;
  localparam int unsigned RT2_IDX = 2;
  localparam int unsigned RD_IDX  = 3;

  localparam logic [CW_DEF-1:0] CTRL_NOP = '0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/idex_entry_reg.sv
// Single payload register with async active-low reset, synchronous clear and load enable.
module idex_entry_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear wins over load so a squash always leaves the entry zeroed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/idex_pipe_stage.sv
// ID->EX pipeline register with ready/valid handshake and a 2-entry (main + skid) buffer.
// Optional IDEX_STAT_EN adds saturating stall and popped-NOP counters.
module idex_pipe_stage
  import idex_pkg::*;
#(
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned CW  = CW_DEF,
  parameter int unsigned RW  = RW_DEF,
  parameter int unsigned NDF = NDF_DEF,
  parameter int unsigned NRF = NRF_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NDF*DW-1:0] in_data,
  input  logic [NRF*RW-1:0] in_regs,
  input  logic [CW-1:0]     in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NDF*DW-1:0] out_data,
  output logic [NRF*RW-1:0] out_regs,
  output logic [CW-1:0]     out_ctrl,
  output logic              out_nop
`ifdef IDEX_STAT_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       nop_cnt
`endif
);

  localparam int unsigned DATA_W = NDF * DW;
  localparam int unsigned REGS_W = NRF * RW;
  localparam int unsigned PW     = CW + REGS_W + DATA_W;

  occ_e          state_q, state_d;
  logic          push, pop;
  logic          main_load, main_from_skid, main_clear;
  logic          skid_load, skid_clear;
  logic          in_ready_q, out_valid_q, nop_q, nop_d;
  logic [PW-1:0] in_pay, main_d, main_q, skid_q;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  // A NOP beat is stored as all-zero payload, so its ctrl field stays 0 as well.
  assign in_pay = (in_ctrl == CW'(CTRL_NOP)) ? '0 : {in_ctrl, in_regs, in_data};
  assign main_d = main_from_skid ? skid_q : in_pay;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_clear     = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      state_d    = EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            main_load = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (push && !pop) begin
            skid_load = 1'b1;
            state_d   = FULL;
          end else if (push && pop) begin
            main_load = 1'b1;
          end else if (pop) begin
            main_clear = 1'b1;
            state_d    = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
            state_d        = ONE;
          end
        end
        default: begin
          state_d    = EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  // Bubble flag follows whatever lands in the main register.
  always_comb begin
    nop_d = nop_q;
    if (main_clear) begin
      nop_d = 1'b0;
    end else if (main_load) begin
      nop_d = (main_d[PW-1 -: CW] == CW'(CTRL_NOP));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      nop_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
      nop_q       <= nop_d;
    end
  end

  idex_entry_reg #(.W(PW)) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .q     (main_q)
  );

  idex_entry_reg #(.W(PW)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (in_pay),
    .q     (skid_q)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_nop   = nop_q;
  assign out_data  = main_q[DATA_W-1:0];
  assign out_regs  = main_q[DATA_W +: REGS_W];
  assign out_ctrl  = main_q[PW-1 -: CW];

`ifdef IDEX_STAT_EN
  logic [15:0] stall_q, nopc_q;

  // Saturating counters; only reset clears them, flush does not.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      nopc_q  <= '0;
    end else begin
      if (out_valid_q && !out_ready && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
      if (pop && nop_q && (nopc_q != 16'hFFFF)) begin
        nopc_q <= nopc_q + 16'd1;
      end
    end
  end

  assign stall_cnt = stall_q;
  assign nop_cnt   = nopc_q;
`endif

endmodule

// File: tb/tb_idex_pipe_stage.sv
// Self-checking bench for idex_pipe_stage: directed scenarios plus random traffic against a queue model.
module tb_idex_pipe_stage;
  import idex_pkg::*;

  localparam int unsigned DW     = 16;
  localparam int unsigned CW     = 16;
  localparam int unsigned RW     = 4;
  localparam int unsigned NDF    = 3;
  localparam int unsigned NRF    = 4;
  localparam int unsigned DATA_W = NDF * DW;
  localparam int unsigned REGS_W = NRF * RW;
  localparam int unsigned PW     = CW + REGS_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, flush, out_valid, out_ready, out_nop;
  logic [DATA_W-1:0] in_data, out_data;
  logic [REGS_W-1:0] in_regs, out_regs;
  logic [CW-1:0]     in_ctrl, out_ctrl;
`ifdef IDEX_STAT_EN
  logic [15:0]       stall_cnt, nop_cnt;
`endif

  idex_pipe_stage #(.DW(DW), .CW(CW), .RW(RW), .NDF(NDF), .NRF(NRF)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_regs   (in_regs),
    .in_ctrl   (in_ctrl),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_regs  (out_regs),
    .out_ctrl  (out_ctrl),
    .out_nop   (out_nop)
`ifdef IDEX_STAT_EN
    ,
    .stall_cnt (stall_cnt),
    .nop_cnt   (nop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a FIFO of at most two beats, NOPs kept as all-zero payloads.
  logic [PW-1:0] mq[$];
  int            m_stall = 0;
  int            m_nop   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [PW-1:0] head;
    logic [CW-1:0] hctrl;
    head  = (mq.size() > 0) ? mq[0] : '0;
    hctrl = head[PW-1 -: CW];
    check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    check("in_ready",  64'(in_ready),  64'(mq.size() < 2));
    check("out_nop",   64'(out_nop),   64'((mq.size() > 0) && (hctrl == '0)));
    check("out_data",  64'(out_data),  64'(head[DATA_W-1:0]));
    check("out_regs",  64'(out_regs),  64'(head[DATA_W +: REGS_W]));
    check("out_ctrl",  64'(out_ctrl),  64'(hctrl));
`ifdef IDEX_STAT_EN
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    check("nop_cnt",   64'(nop_cnt),   64'(m_nop));
`endif
  endtask

  // One clock: drive at the falling edge, update the model, check just after the rising edge.
  task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic [REGS_W-1:0] r,
                       input logic [CW-1:0] c, input logic ro, input logic fl);
    logic          do_push, do_pop;
    logic [PW-1:0] beat, head;
    in_valid  = v;
    in_data   = d;
    in_regs   = r;
    in_ctrl   = c;
    out_ready = ro;
    flush     = fl;
    do_push = v && (mq.size() < 2);
    do_pop  = (mq.size() > 0) && ro;
    head    = (mq.size() > 0) ? mq[0] : '0;
    beat    = (c == '0) ? '0 : {c, r, d};
    if ((mq.size() > 0) && !ro && (m_stall < 65535)) m_stall++;
    if (do_pop && (head[PW-1 -: CW] == '0) && (m_nop < 65535)) m_nop++;
    @(posedge clk);
    #1;
    if (fl) begin
      mq.delete();
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(beat);
    end
    check_all();
    @(negedge clk);
  endtask

  task automatic idle(input logic ro, input logic fl);
    cycle(1'b0, '0, '0, '0, ro, fl);
  endtask

  function automatic logic [REGS_W-1:0] mk_regs(input logic [RW-1:0] rs, input logic [RW-1:0] rd);
    logic [REGS_W-1:0] r;
    r = '0;
    r[RS_IDX*RW +: RW] = rs;
    r[RD_IDX*RW +: RW] = rd;
    return r;
  endfunction

  initial begin
    logic [DATA_W-1:0] d;
    rst = 1'b0;
    in_valid = 1'b0; in_data = '0; in_regs = '0; in_ctrl = '0;
    flush = 1'b0; out_ready = 1'b0;
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single beat, immediate consumer
    cycle(1'b1, DATA_W'(16'h1234), mk_regs(4'd3, 4'd5), 16'h0011, 1'b1, 1'b0);
    check("t1_op0", 64'(out_data[15:0]), 64'h1234);
    check("t1_rd",  64'(out_regs[RD_IDX*RW +: RW]), 64'd5);
    idle(1'b1, 1'b0);

    // Back-pressure: A, B fill both entries, C waits, then all drain in order
    cycle(1'b1, DATA_W'(16'hA0A0), mk_regs(4'd1, 4'd2), 16'h00A1, 1'b0, 1'b0);
    cycle(1'b1, DATA_W'(16'hB0B0), mk_regs(4'd3, 4'd4), 16'h00B1, 1'b0, 1'b0);
    check("bp_full_ready", 64'(in_ready), 64'd0);
    cycle(1'b1, DATA_W'(16'hC0C0), mk_regs(4'd5, 4'd6), 16'h00C1, 1'b0, 1'b0);
    cycle(1'b1, DATA_W'(16'hC0C0), mk_regs(4'd5, 4'd6), 16'h00C1, 1'b1, 1'b0);
    cycle(1'b1, DATA_W'(16'hC0C0), mk_regs(4'd5, 4'd6), 16'h00C1, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);

    // NOP with non-zero data is zeroed
    cycle(1'b1, DATA_W'(16'hBEEF), mk_regs(4'd7, 4'd8), 16'h0000, 1'b0, 1'b0);
    check("nop_flag", 64'(out_nop), 64'd1);
    idle(1'b1, 1'b0);

    // Flush while FULL with a simultaneous push D
    cycle(1'b1, DATA_W'(16'h1111), mk_regs(4'd1, 4'd1), 16'h0101, 1'b0, 1'b0);
    cycle(1'b1, DATA_W'(16'h2222), mk_regs(4'd2, 4'd2), 16'h0202, 1'b0, 1'b0);
    cycle(1'b1, DATA_W'(16'hDDDD), mk_regs(4'd13, 4'd13), 16'h0D0D, 1'b0, 1'b1);
    check("flush_valid", 64'(out_valid), 64'd0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);

    // Async reset mid-stall while FULL
    cycle(1'b1, DATA_W'(16'h3333), mk_regs(4'd3, 4'd3), 16'h0303, 1'b0, 1'b0);
    cycle(1'b1, DATA_W'(16'h4444), mk_regs(4'd4, 4'd4), 16'h0404, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    mq.delete();
    m_stall = 0;
    m_nop   = 0;
    check_all();
    @(negedge clk);
    rst = 1'b1;
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);

    // Statistics: five stall cycles and two popped NOPs, then a flush
    cycle(1'b1, DATA_W'(16'h5555), '0, '0, 1'b0, 1'b0);
    cycle(1'b1, DATA_W'(16'h6666), '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b0, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
`ifdef IDEX_STAT_EN
    check("stat_stall5", 64'(stall_cnt), 64'd5);
    check("stat_nop2",   64'(nop_cnt),   64'd2);
`endif
    cycle(1'b1, DATA_W'(16'h7777), mk_regs(4'd7, 4'd7), 16'h0707, 1'b0, 1'b0);
    idle(1'b0, 1'b1);
`ifdef IDEX_STAT_EN
    check("stat_stall_keep", 64'(stall_cnt), 64'd6);
    check("stat_nop_keep",   64'(nop_cnt),   64'd2);
`endif

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      d = DATA_W'({$urandom, $urandom});
      cycle(1'($urandom_range(0, 99) < 60),
            d,
            REGS_W'($urandom),
            ($urandom_range(0, 99) < 20) ? '0 : CW'($urandom),
            1'($urandom_range(0, 99) < 55),
            1'($urandom_range(0, 99) < 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/idex_pipe_stage.md
Name: idex_pipe_stage

Overview:
Parametrised ID->EX pipeline register with a ready/valid handshake and a 2-entry skid buffer, so the decode and execute stages can stall each other without dropping instructions.
- Carries NDF data operands, NRF register-index fields and one control word.
- Ctrl==0 is an explicit NOP/bubble; flush squashes all in-flight contents.
- Sits between the decode/register-file read logic and the ALU/forwarding stage.

Parameters:
DW, 16, operand data width
CW, 16, control word width
RW, 4, register-index width
NDF, 3, number of data operands (packed)
NRF, 4, number of register-index fields (RS, RT1, RT2, RD order, index 0 = RS)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
in_valid  in  1  decode presents a beat
in_ready  out  1  stage can accept a beat
in_data  in  NDF*DW  operands, operand k at [k*DW +: DW]
in_regs  in  NRF*RW  register indices, field k at [k*RW +: RW]
in_ctrl  in  CW  control word; 0 = NOP
flush  in  1  synchronous squash (branch/exception)
out_valid  out  1  beat available to EX
out_ready  in  1  EX consumes beat
out_data  out  NDF*DW  registered operands
out_regs  out  NRF*RW  registered indices
out_ctrl  out  CW  registered control
out_nop  out  1  current output beat is a bubble (out_ctrl==0)

Behaviour:
- Reset (rst=0, async): both entries invalid; all out_* = 0; out_valid=0, out_nop=0; in_ready=1. Reset mid-transfer discards all contents.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- Latency: 1 cycle, accepted beat appears on out_* the next cycle. Outputs are driven straight from the main register, with no combinational path from in_* to out_*.
- in_ready = !skid_valid (registered), so there is no combinational in_ready/out_ready path.
- State machine over occupancy:
  - EMPTY: push -> ONE (main<=in).
  - ONE: push&!pop -> FULL (skid<=in). push&pop -> ONE (main<=in). pop&!push -> EMPTY. Otherwise hold.
  - FULL: in_ready=0. pop -> ONE (main<=skid). Otherwise hold.
- NOP handling: a pushed beat with in_ctrl==0 is stored with data and regs forced to 0.
  - It still occupies an entry and is presented with out_valid=1, out_nop=1.
  - EX pops it normally.
- Flush: next cycle both entries are invalid, out_* = 0, state EMPTY, in_ready=1.
  - A beat pushed in the flush cycle is dropped.
  - A pop in the flush cycle completes; the consumer takes the current beat.
  - Flush has priority over push/pop state updates.
- Held outputs are stable while out_valid&!out_ready (no change until pop or flush).
- Order is strictly FIFO; no reordering and no duplication across the skid path.

Optional Feature:
IDEX_STAT_EN:
- Defined: adds output ports stall_cnt[15:0] and nop_cnt[15:0].
  - stall_cnt increments each cycle with out_valid&!out_ready.
  - nop_cnt increments per popped NOP beat.
  - Both saturate at 16'hFFFF, reset to 0 asynchronously, and are not cleared by flush.
- Undefined: ports and logic absent; handshake behaviour identical.

Decomposition:
- Package idex_pkg: default widths, field index constants (RS_IDX=0, RT1_IDX=1, RT2_IDX=2, RD_IDX=3), CTRL_NOP='0, occupancy state enum (EMPTY, ONE, FULL).
- One sub-module, idex_entry_reg: a single payload register with async active-low reset, load enable and clear. It is instantiated twice (main, skid).

Test Plan:
- Reset then single beat: in_data op0=16'h1234, regs RS=3/RD=5, ctrl=16'h0011, out_ready=1 -> next cycle out_valid=1, out_data op0=16'h1234, out_regs RD=5, out_nop=0.
- Back-pressure: out_ready=0, push beats A, B -> in_ready=0 after B; third beat C held by decode. Raise out_ready -> A, B, C emerge in order, one per cycle, none lost.
- NOP: push ctrl=0 with data 16'hBEEF -> out_valid=1, out_nop=1, out_data=0, out_regs=0.
- Flush while FULL with simultaneous push D -> next cycle out_valid=0, in_ready=1, and D never appears on the output.
- Async reset asserted mid-stall while FULL -> outputs 0 immediately, in_ready=1, no stale beat after release.
- IDEX_STAT_EN: 5 stall cycles plus 2 popped NOPs -> stall_cnt=5, nop_cnt=2; a subsequent flush leaves both counts unchanged.
